// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ADDR, RESP)
//   ADDR_W/DATA_W/BE_W : fixed memory-side field widths, also the strides
//                        of the flattened requester buses
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i    : request vector, one bit per requester
//   ptr_i    : index of the most recently served requester
//   found_o  : at least one request is pending
//   winner_o : first requesting index scanning ptr_i+1, ptr_i+2, ... mod NUM_REQ
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   winner_o
);

    // One spare bit so ptr_i + NUM_REQ never overflows before the wrap.
    logic [IDX_W:0] cand_s;

    // Scan from the farthest offset down to the nearest so the nearest
    // requesting index (after ptr_i) is the last one written and wins.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        cand_s   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand_s = {1'b0, ptr_i} + (IDX_W+1)'(i);
            // Wrap modulo NUM_REQ, which need not be a power of two.
            if (cand_s >= (IDX_W+1)'(NUM_REQ)) begin
                cand_s = cand_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (req_i[cand_s[IDX_W-1:0]]) begin
                found_o  = 1'b1;
                winner_o = cand_s[IDX_W-1:0];
            end else begin
                found_o  = found_o;
                winner_o = winner_o;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/gnt/rvalid memory port between NUM_REQ
// masters with round-robin arbitration and one outstanding transaction.
//   clk, reset            : clock, async active-high reset
//   req_*_i               : flattened requester buses (strides 32/32/1/4)
//   req_gnt_o/rvalid_o/error_o : per-requester handshake, one-hot or zero
//   req_rdata_o           : memory read data broadcast to all requesters
//   mem_*                 : single memory port; address-phase fields are
//                           registered copies taken at arbitration
//   owner_o, busy_o       : debug: current/last owner, FSM not idle
//   proto_err_o           : sticky, memory rvalid seen outside RESP
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*BE_W-1:0]   req_be_i,
    output logic [NUM_REQ-1:0]        req_gnt_o,
    output logic [NUM_REQ-1:0]        req_rvalid_o,
    output logic [DATA_W-1:0]         req_rdata_o,
    output logic [NUM_REQ-1:0]        req_error_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    output logic                      mem_we_o,
    output logic                      mem_req_o,
    output logic [BE_W-1:0]           mem_be_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic                      mem_error_i,
    output logic [IDX_W-1:0]          owner_o,
    output logic                      busy_o,
    output logic                      proto_err_o
);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                we_q, we_d;
    logic                mem_req_q, mem_req_d;
    logic                busy_q, busy_d;
    logic                proto_err_q, proto_err_d;

    logic                pick_found_s;
    logic [IDX_W-1:0]    pick_idx_s;

    logic [ADDR_W-1:0]   addr_arr_s  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr_s [NUM_REQ];
    logic [BE_W-1:0]     be_arr_s    [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unflatten
        assign addr_arr_s[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
        assign wdata_arr_s[k] = req_wdata_i[k*DATA_W +: DATA_W];
        assign be_arr_s[k]    = req_be_i[k*BE_W +: BE_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (req_req_i),
        .ptr_i    (rr_ptr_q),
        .found_o  (pick_found_s),
        .winner_o (pick_idx_s)
    );

    // Next-state logic: arbitration, field latching and handshake tracking.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        we_d     = we_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    state_d = ADDR;
                    owner_d = pick_idx_s;
                    addr_d  = addr_arr_s[pick_idx_s];
                    wdata_d = wdata_arr_s[pick_idx_s];
                    be_d    = be_arr_s[pick_idx_s];
                    we_d    = req_we_i[pick_idx_s];
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                // Once granted, the pointer moves to the owner so the next
                // scan starts just past it.
                if (mem_gnt_i) begin
                    state_d  = RESP;
                    rr_ptr_d = owner_q;
                end else begin
                    state_d = ADDR;
                end
            end
            RESP: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // mem_req and busy are registered from the next state so the
        // memory side sees clean flop outputs rather than a state decode.
        mem_req_d   = (state_d == ADDR);
        busy_d      = (state_d != IDLE);
        // An rvalid in IDLE or ADDR (including together with gnt) cannot
        // belong to the current transaction.
        proto_err_d = proto_err_q | (mem_rvalid_i & (state_q != RESP));
    end

    // State and latched-field registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            we_q        <= we_d;
            mem_req_q   <= mem_req_d;
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Zero-latency steering of memory gnt/rvalid/error to the owner.
    always_comb begin
        req_gnt_o    = '0;
        req_rvalid_o = '0;
        req_error_o  = '0;
        if (mem_req_q) begin
            req_gnt_o[owner_q] = mem_gnt_i;
        end else begin
            req_gnt_o = '0;
        end
        if (state_q == RESP) begin
            req_rvalid_o[owner_q] = mem_rvalid_i;
            req_error_o[owner_q]  = mem_rvalid_i & mem_error_i;
        end else begin
            req_rvalid_o = '0;
            req_error_o  = '0;
        end
    end

    assign req_rdata_o = mem_rdata_i;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign owner_o     = owner_q;
    assign busy_o      = busy_q;
    assign proto_err_o = proto_err_q;

endmodule
